// File: rtl/jtframe_db15_reader.sv
// DB15 adapter reader: scans a 32-bit 74HC165 chain and publishes two 16-bit active-high joystick words.
// Optional build macro JTFRAME_DB15_DEBOUNCE_EN publishes only after two identical consecutive valid scans.
module jtframe_db15_reader #(
  parameter int CLKDIV = 48,
  parameter int GAP    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load_n,
  output logic [15:0] board_joy1,
  output logic [15:0] board_joy2,
  output logic        connected,
  output logic        scan_done
);

  localparam int CW = $clog2(CLKDIV);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKDIV - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BIT_LO,
    BIT_HI,
    DONE
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic [4:0]    idx;
  logic [31:0]   raw;
  logic          tick;
  logic          raw_valid;
  logic          data_s;

`ifdef JTFRAME_DB15_DEBOUNCE_EN
  logic [31:0]   raw_prev;
  logic          hist_vld;
`endif

  assign tick      = (cnt == CNT_MAX);
  assign data_s    = sync[1];
  // A line stuck low reads as every button pressed: treat as unplugged/faulty.
  assign raw_valid = (raw != 32'hFFFF_FFFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], joy_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      gap_cnt    <= '0;
      idx        <= '0;
      raw        <= '0;
      joy_clk    <= 1'b0;
      joy_load_n <= 1'b1;
      board_joy1 <= '0;
      board_joy2 <= '0;
      connected  <= 1'b0;
      scan_done  <= 1'b0;
`ifdef JTFRAME_DB15_DEBOUNCE_EN
      raw_prev   <= '0;
      hist_vld   <= 1'b0;
`endif
    end else begin
      scan_done <= 1'b0;
      // DONE is a single clk cycle, so the tick phase restarts afterwards.
      if (state == DONE || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          joy_clk    <= 1'b0;
          joy_load_n <= 1'b1;
          if (tick) begin
            if (gap_cnt == GAP_MAX) begin
              gap_cnt    <= '0;
              joy_load_n <= 1'b0;
              state      <= LOAD;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
        end

        LOAD: begin
          idx <= '0;
          if (tick) begin
            joy_load_n <= 1'b1;
            state      <= BIT_LO;
          end
        end

        BIT_LO: begin
          if (tick) begin
            raw[idx] <= ~data_s;
            joy_clk  <= 1'b1;
            state    <= BIT_HI;
          end
        end

        BIT_HI: begin
          if (tick) begin
            joy_clk <= 1'b0;
            if (idx == 5'd31) begin
              state <= DONE;
            end else begin
              idx   <= idx + 5'd1;
              state <= BIT_LO;
            end
          end
        end

        DONE: begin
          scan_done <= 1'b1;
          state     <= IDLE;
          if (!raw_valid) begin
            connected  <= 1'b0;
            board_joy1 <= '0;
            board_joy2 <= '0;
`ifdef JTFRAME_DB15_DEBOUNCE_EN
            hist_vld   <= 1'b0;
`endif
          end else begin
            connected <= 1'b1;
`ifdef JTFRAME_DB15_DEBOUNCE_EN
            if (hist_vld && raw == raw_prev) begin
              board_joy1 <= raw[15:0];
              board_joy2 <= raw[31:16];
            end
            raw_prev <= raw;
            hist_vld <= 1'b1;
`else
            board_joy1 <= raw[15:0];
            board_joy2 <= raw[31:16];
`endif
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_db15_reader.sv
// Bench for jtframe_db15_reader: 74HC165 chain model, table vectors, random scans vs a rule-level model.
module tb_jtframe_db15_reader;
  localparam int CLKDIV = 4;
  localparam int GAP    = 2;
  localparam int PERIOD = (GAP + 1 + 64) * CLKDIV + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        joy_data;
  logic        joy_clk, joy_load_n, connected, scan_done;
  logic [15:0] board_joy1, board_joy2;

  always #5 clk = ~clk;

  jtframe_db15_reader #(.CLKDIV(CLKDIV), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .joy_data  (joy_data),
    .joy_clk   (joy_clk),
    .joy_load_n(joy_load_n),
    .board_joy1(board_joy1),
    .board_joy2(board_joy2),
    .connected (connected),
    .scan_done (scan_done)
  );

  // Shift-register chain: pressed bits drive the line low, bit 0 comes out first.
  logic [31:0] pressed = '0;
  logic [31:0] sh = '1;
  always @(posedge joy_clk or negedge joy_load_n) begin
    if (!joy_load_n) sh <= ~pressed;
    else             sh <= {1'b1, sh[31:1]};
  end
  assign joy_data = sh[0];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Observers of the external waveform
  int edges = 0, load_lo = 0, period_cnt = 0, scans = 0, glitch = 0;
  int last_edges = 0, last_load_lo = 0, last_period = 0;
  logic prev_jclk = 1'b0;
  logic [32:0] prev_out = '0;
  always @(negedge clk) begin
    if (rst) begin
      edges = 0; load_lo = 0; period_cnt = 0;
    end else begin
      if (joy_clk && !prev_jclk) edges++;
      if (!joy_load_n) load_lo++;
      period_cnt++;
      if ({connected, board_joy2, board_joy1} != prev_out && !scan_done) glitch++;
      if (scan_done) begin
        scans++;
        last_edges = edges; last_load_lo = load_lo; last_period = period_cnt;
        edges = 0; load_lo = 0; period_cnt = 0;
      end
    end
    prev_jclk = joy_clk;
    prev_out  = {connected, board_joy2, board_joy1};
  end

  // Rule-level reference model of what each completed scan publishes
  logic [15:0] m_j1 = '0, m_j2 = '0;
  logic        m_conn = 1'b0;
  logic [31:0] m_prev = '0;
  bit          m_hist = 1'b0;

  task automatic model_reset();
    m_j1 = '0; m_j2 = '0; m_conn = 1'b0; m_hist = 1'b0;
  endtask

  task automatic model_scan(input logic [31:0] p);
    if (p == 32'hFFFF_FFFF) begin
      m_conn = 1'b0; m_j1 = '0; m_j2 = '0; m_hist = 1'b0;
    end else begin
      m_conn = 1'b1;
`ifdef JTFRAME_DB15_DEBOUNCE_EN
      if (m_hist && p == m_prev) begin
        m_j1 = p[15:0]; m_j2 = p[31:16];
      end
      m_prev = p; m_hist = 1'b1;
`else
      m_j1 = p[15:0]; m_j2 = p[31:16];
`endif
    end
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < 2 * PERIOD);
    ok = scan_done;
  endtask

  task automatic run_scan(input logic [31:0] p);
    bit ok;
    pressed = p;
    wait_done(ok);
    chk("scan_timeout", {31'd0, ok}, 32'd1);
    model_scan(p);
  endtask

  typedef struct {
    logic [31:0] p;
    logic [15:0] j1;
    logic [15:0] j2;
    logic        conn;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ecount;
    int scans_before;
    logic pj;
    logic [31:0] p;
    logic [31:0] last_p;
    logic [15:0] exp_j1;

    vecs[0] = '{32'h0000_0000, 16'h0000, 16'h0000, 1'b1};
    vecs[1] = '{32'h0010_0001, 16'h0001, 16'h0010, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{32'h0000_0000, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{32'h8000_0000, 16'h0000, 16'h8000, 1'b1};
    vecs[5] = '{32'h0000_8000, 16'h8000, 16'h0000, 1'b1};
    vecs[6] = '{32'hA5A5_5A5A, 16'h5A5A, 16'hA5A5, 1'b1};
    vecs[7] = '{32'hFFFF_FFFE, 16'hFFFE, 16'hFFFF, 1'b1};
    vecs[8] = '{32'hFFFF_FFFF, 16'h0000, 16'h0000, 1'b0};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_joy_clk", {31'd0, joy_clk}, 32'd0);
    chk("rst_load_n", {31'd0, joy_load_n}, 32'd1);
    chk("rst_joy1", {16'd0, board_joy1}, 32'd0);
    chk("rst_joy2", {16'd0, board_joy2}, 32'd0);
    chk("rst_connected", {31'd0, connected}, 32'd0);
    chk("rst_scan_done", {31'd0, scan_done}, 32'd0);
    model_reset();

    // First load falls GAP ticks after release, first scan lands one period after release
    rst = 1'b0;
    n = 0;
    while (joy_load_n && n < 2 * PERIOD) begin @(negedge clk); n++; end
    chk("first_load_delay", n, GAP * CLKDIV);
    while (!scan_done && n < 2 * PERIOD) begin @(negedge clk); n++; end
    chk("first_scan_delay", n, PERIOD);
    model_scan(32'h0);
    chk("first_connected", {31'd0, connected}, 32'd1);

    // Waveform shape and the bit 0 / bit 20 pattern
    run_scan(32'h0010_0001);
    #1;
    chk("edges_per_scan", last_edges, 32);
    chk("load_low_cycles", last_load_lo, CLKDIV);
    chk("scan_period", last_period, PERIOD);
    @(negedge clk);
    chk("scan_done_width", {31'd0, scan_done}, 32'd0);
    run_scan(32'h0010_0001);
    chk("b0b20_joy1", {16'd0, board_joy1}, 32'h0001);
    chk("b0b20_joy2", {16'd0, board_joy2}, 32'h0010);
    chk("b0b20_conn", {31'd0, connected}, 32'd1);

    // Table vectors: each applied for two scans so both builds settle
    for (int i = 0; i < 9; i++) begin
      run_scan(vecs[i].p);
      chk("tbl_conn_first", {31'd0, connected}, {31'd0, vecs[i].conn});
      run_scan(vecs[i].p);
      chk("tbl_joy1", {16'd0, board_joy1}, {16'd0, vecs[i].j1});
      chk("tbl_joy2", {16'd0, board_joy2}, {16'd0, vecs[i].j2});
      chk("tbl_conn", {31'd0, connected}, {31'd0, vecs[i].conn});
    end

    // Single-scan press on player 1
    run_scan(32'h0);
    run_scan(32'h0);
    run_scan(32'h0000_0002);
`ifdef JTFRAME_DB15_DEBOUNCE_EN
    exp_j1 = 16'h0000;
`else
    exp_j1 = 16'h0002;
`endif
    chk("pulse_joy1", {16'd0, board_joy1}, {16'd0, exp_j1});
    run_scan(32'h0);
    chk("pulse_joy1_after", {16'd0, board_joy1}, 32'd0);

    // Random scans against the model
    last_p = 32'h0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       p = 32'hFFFF_FFFF;
        1, 2:    p = last_p;
        3:       p = {16'd0, 16'($urandom)};
        default: p = $urandom;
      endcase
      run_scan(p);
      last_p = p;
      chk("rnd_joy1", {16'd0, board_joy1}, {16'd0, m_j1});
      chk("rnd_joy2", {16'd0, board_joy2}, {16'd0, m_j2});
      chk("rnd_conn", {31'd0, connected}, {31'd0, m_conn});
    end

    // Reset while BIT_HI holds index 10
    run_scan(32'h1234_5678);
    run_scan(32'h1234_5678);
    chk("pre_rst_joy1", {16'd0, board_joy1}, 32'h5678);
    pressed = 32'h0F0F_0F0F;
    n = 0;
    while (joy_load_n && n < 2 * PERIOD) begin @(negedge clk); n++; end
    chk("load_seen", {31'd0, joy_load_n}, 32'd0);
    ecount = 0; pj = joy_clk; n = 0;
    while (ecount < 11 && n < 2 * PERIOD) begin
      @(negedge clk); n++;
      if (joy_clk && !pj) ecount++;
      pj = joy_clk;
    end
    chk("reached_idx10", ecount, 11);
    #1;
    scans_before = scans;
    rst = 1'b1;
    #1;
    chk("mid_rst_joy_clk", {31'd0, joy_clk}, 32'd0);
    chk("mid_rst_load_n", {31'd0, joy_load_n}, 32'd1);
    chk("mid_rst_joy1", {16'd0, board_joy1}, 32'd0);
    chk("mid_rst_joy2", {16'd0, board_joy2}, 32'd0);
    chk("mid_rst_conn", {31'd0, connected}, 32'd0);
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!scan_done && n < 2 * PERIOD);
    chk("rst_scan_delay", n, PERIOD);
    chk("no_partial_scan", scans - scans_before, 0);
    model_scan(32'h0F0F_0F0F);
    chk("post_rst_conn", {31'd0, connected}, {31'd0, m_conn});
    chk("post_rst_joy1", {16'd0, board_joy1}, {16'd0, m_j1});

    #1;
    chk("outputs_stable", glitch, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
